banco_registros_sb: RTL and testbench

- Second-generation register file for the pipelined core.
- Generalised in depth and width; two combinational read ports and one write port.
- Adds a hardwired-zero register, optional write-to-read bypass, and a per-register busy scoreboard with flush.
- Issue stage reserves destination registers; writeback clears them; decode reads data plus busy flags to detect hazards.

---
 rtl/banco_registros_sb.sv | 94 +++++++++
 tb/tb_banco_registros_sb.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/banco_registros_sb.sv
// banco_registros_sb: parameterised register file with two read ports,
// one write port, optional bypass, hardwired zero and a busy scoreboard.
module banco_registros_sb #(
  parameter  int N        = 32,
  parameter  int Bits     = 64,
  parameter  int ZERO_REG = 1,
  parameter  int BYPASS   = 1,
  localparam int AW       = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   ptr_rd_1,
  input  logic [AW-1:0]   ptr_rd_2,
  output logic [Bits-1:0] data_rd_1,
  output logic [Bits-1:0] data_rd_2,
  output logic            busy_rd_1,
  output logic            busy_rd_2,
  input  logic [AW-1:0]   ptr_wr,
  input  logic [Bits-1:0] data_wr,
  input  logic            wr_en,
  input  logic            rsv_en,
  input  logic [AW-1:0]   ptr_rsv,
  output logic            rsv_ok,
  input  logic            flush,
  output logic [AW:0]     busy_cnt
);

  logic [Bits-1:0] regs [N];
  logic [N-1:0]    busy;
  logic [N-1:0]    busy_nxt;
  logic            wr_ok;
  logic            rsv_set;
  logic            inc;
  logic            dec;
  logic [AW:0]     cnt_nxt;

  assign wr_ok = wr_en & ~((ZERO_REG != 0) && (ptr_wr == '0));

  // a busy target is still grantable when its writeback lands this cycle
  assign rsv_ok = rst & rsv_en & ~flush &
                  (~busy[ptr_rsv] | (wr_en & (ptr_wr == ptr_rsv)));

  assign rsv_set = rsv_ok & ~((ZERO_REG != 0) && (ptr_rsv == '0));

  assign inc = rsv_set & ~busy[ptr_rsv];
  assign dec = wr_en & busy[ptr_wr] &
               ~(rsv_set & (ptr_rsv == ptr_wr));

  always_comb begin
    busy_nxt = busy;
    if (flush) begin
      busy_nxt = '0;
    end else begin
      if (wr_en)   busy_nxt[ptr_wr]  = 1'b0;
      if (rsv_set) busy_nxt[ptr_rsv] = 1'b1;
    end
  end

  always_comb begin
    cnt_nxt = busy_cnt + (AW+1)'(inc) - (AW+1)'(dec);
    if (flush) cnt_nxt = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) regs[i] <= '0;
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      if (wr_ok) regs[ptr_wr] <= data_wr;
      busy     <= busy_nxt;
      busy_cnt <= cnt_nxt;
    end
  end

  always_comb begin
    data_rd_1 = regs[ptr_rd_1];
    busy_rd_1 = busy[ptr_rd_1];
    if ((BYPASS != 0) && wr_ok && (ptr_wr == ptr_rd_1)) begin
      data_rd_1 = data_wr;
      busy_rd_1 = rsv_set && (ptr_rsv == ptr_rd_1);
    end
  end

  always_comb begin
    data_rd_2 = regs[ptr_rd_2];
    busy_rd_2 = busy[ptr_rd_2];
    if ((BYPASS != 0) && wr_ok && (ptr_wr == ptr_rd_2)) begin
      data_rd_2 = data_wr;
      busy_rd_2 = rsv_set && (ptr_rsv == ptr_rd_2);
    end
  end

endmodule

// File: tb/tb_banco_registros_sb.sv
// tb_banco_registros_sb: directed scoreboard bench for banco_registros_sb
// (bypassing instance plus a BYPASS=0 twin on the same stimulus).
module tb_banco_registros_sb;

  logic        clk;
  logic        rst;
  logic [4:0]  ptr_rd_1, ptr_rd_2, ptr_wr, ptr_rsv;
  logic [63:0] data_wr;
  logic        wr_en, rsv_en, flush;
  logic [63:0] d1, d2, nd1, nd2;
  logic        b1, b2, nb1, nb2;
  logic        ok, nok;
  logic [5:0]  cnt, ncnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [63:0] val;
  } exp_t;
  exp_t sb[$];

  banco_registros_sb dut (
    .clk(clk), .rst(rst),
    .ptr_rd_1(ptr_rd_1), .ptr_rd_2(ptr_rd_2),
    .data_rd_1(d1), .data_rd_2(d2),
    .busy_rd_1(b1), .busy_rd_2(b2),
    .ptr_wr(ptr_wr), .data_wr(data_wr), .wr_en(wr_en),
    .rsv_en(rsv_en), .ptr_rsv(ptr_rsv), .rsv_ok(ok),
    .flush(flush), .busy_cnt(cnt)
  );

  banco_registros_sb #(.BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst),
    .ptr_rd_1(ptr_rd_1), .ptr_rd_2(ptr_rd_2),
    .data_rd_1(nd1), .data_rd_2(nd2),
    .busy_rd_1(nb1), .busy_rd_2(nb2),
    .ptr_wr(ptr_wr), .data_wr(data_wr), .wr_en(wr_en),
    .rsv_en(rsv_en), .ptr_rsv(ptr_rsv), .rsv_ok(nok),
    .flush(flush), .busy_cnt(ncnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic expect_v(input string tag, input logic [63:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic cmp(input logic [63:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed=%h expected=none", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  // advance past one rising edge, then drop all enables
  task automatic tick();
    @(negedge clk);
    wr_en  = 1'b0;
    rsv_en = 1'b0;
    flush  = 1'b0;
  endtask

  task automatic rsv(input logic [4:0] p);
    rsv_en  = 1'b1;
    ptr_rsv = p;
    tick();
  endtask

  initial begin
    rst = 1'b0; wr_en = 1'b1; ptr_wr = 5'd3; data_wr = 64'hAA;
    rsv_en = 1'b1; ptr_rsv = 5'd3; flush = 1'b0;
    ptr_rd_1 = 5'd0; ptr_rd_2 = 5'd3;
    repeat (2) @(negedge clk);
    #2;
    expect_v("rsv_ok_in_reset", 64'd0); cmp(64'(ok));
    @(negedge clk);
    rst = 1'b1; wr_en = 1'b0; rsv_en = 1'b0;
    #2;
    expect_v("reset_cnt", 64'd0);   cmp(64'(cnt));
    expect_v("reset_reg3", 64'd0);  cmp(d2);
    expect_v("reset_busy3", 64'd0); cmp(64'(b2));

    // write loop
    for (int i = 0; i < 32; i++) begin
      wr_en = 1'b1; ptr_wr = 5'(i); data_wr = 64'(i);
      tick();
    end
    for (int k = 0; k < 16; k++) begin
      ptr_rd_1 = 5'(2*k+1); ptr_rd_2 = 5'(2*k);
      #2;
      expect_v("loop_rd1", 64'(2*k+1)); cmp(d1);
      expect_v("loop_rd2", 64'(2*k));   cmp(d2);
      @(negedge clk);
    end

    // bypass vs no bypass
    wr_en = 1'b1; ptr_wr = 5'd5; data_wr = 64'hDEAD_BEEF_0000_0005;
    ptr_rd_1 = 5'd5;
    #2;
    expect_v("bypass_data", 64'hDEAD_BEEF_0000_0005); cmp(d1);
    expect_v("nobypass_old", 64'd5); cmp(nd1);
    tick(); #2;
    expect_v("nobypass_new", 64'hDEAD_BEEF_0000_0005); cmp(nd1);

    // zero register
    wr_en = 1'b1; ptr_wr = 5'd0; data_wr = 64'hFF; ptr_rd_2 = 5'd0;
    #2;
    expect_v("zero_bypass", 64'd0); cmp(d2);
    tick(); #2;
    expect_v("zero_after", 64'd0); cmp(d2);
    rsv_en = 1'b1; ptr_rsv = 5'd0;
    #2;
    expect_v("rsv0_ok", 64'd1); cmp(64'(ok));
    tick(); #2;
    expect_v("rsv0_cnt", 64'd0);  cmp(64'(cnt));
    expect_v("rsv0_busy", 64'd0); cmp(64'(b2));

    // scoreboard
    rsv_en = 1'b1; ptr_rsv = 5'd7; ptr_rd_1 = 5'd7;
    #2;
    expect_v("rsv7_ok", 64'd1); cmp(64'(ok));
    tick();
    rsv_en = 1'b1; ptr_rsv = 5'd7;
    #2;
    expect_v("rsv7_busy", 64'd1);  cmp(64'(b1));
    expect_v("rsv7_cnt", 64'd1);   cmp(64'(cnt));
    expect_v("rsv7_again", 64'd0); cmp(64'(ok));
    tick(); #2;
    expect_v("rsv7_cnt_hold", 64'd1); cmp(64'(cnt));
    wr_en = 1'b1; ptr_wr = 5'd7; data_wr = 64'h77;
    #2;
    expect_v("wb7_bypass_busy", 64'd0); cmp(64'(b1));
    tick(); #2;
    expect_v("wb7_busy", 64'd0); cmp(64'(b1));
    expect_v("wb7_cnt", 64'd0);  cmp(64'(cnt));
    expect_v("wb7_data", 64'h77); cmp(d1);

    // simultaneous writeback and reservation of the same register
    rsv(5'd9);
    wr_en = 1'b1; ptr_wr = 5'd9; data_wr = 64'h99;
    rsv_en = 1'b1; ptr_rsv = 5'd9; ptr_rd_2 = 5'd9;
    #2;
    expect_v("wr_rsv9_ok", 64'd1);     cmp(64'(ok));
    expect_v("wr_rsv9_bbusy", 64'd1);  cmp(64'(b2));
    expect_v("wr_rsv9_bdata", 64'h99); cmp(d2);
    tick(); #2;
    expect_v("wr_rsv9_busy", 64'd1);  cmp(64'(b2));
    expect_v("wr_rsv9_cnt", 64'd1);   cmp(64'(cnt));
    expect_v("wr_rsv9_data", 64'h99); cmp(d2);

    // reserve 3 while 4 writes back
    rsv(5'd4);
    wr_en = 1'b1; ptr_wr = 5'd4; data_wr = 64'h44;
    rsv_en = 1'b1; ptr_rsv = 5'd3;
    ptr_rd_1 = 5'd3; ptr_rd_2 = 5'd4;
    #2;
    expect_v("rsv3_wb4_cnt_pre", 64'd2); cmp(64'(cnt));
    tick(); #2;
    expect_v("rsv3_wb4_cnt", 64'd2);   cmp(64'(cnt));
    expect_v("rsv3_busy3", 64'd1);     cmp(64'(b1));
    expect_v("rsv3_busy4", 64'd0);     cmp(64'(b2));

    // flush
    flush = 1'b1;
    tick(); #2;
    expect_v("flush_clear_cnt", 64'd0); cmp(64'(cnt));
    rsv(5'd1); rsv(5'd2); rsv(5'd3);
    #2;
    expect_v("rsv123_cnt", 64'd3); cmp(64'(cnt));
    flush = 1'b1; wr_en = 1'b1; ptr_wr = 5'd2; data_wr = 64'h22;
    rsv_en = 1'b1; ptr_rsv = 5'd6;
    #2;
    expect_v("flush_rsv_ok", 64'd0); cmp(64'(ok));
    tick();
    ptr_rd_1 = 5'd2; ptr_rd_2 = 5'd6;
    #2;
    expect_v("flush_cnt", 64'd0);    cmp(64'(cnt));
    expect_v("flush_data2", 64'h22); cmp(d1);
    expect_v("flush_busy2", 64'd0);  cmp(64'(b1));
    expect_v("flush_busy6", 64'd0);  cmp(64'(b2));

    // reset mid-operation
    rsv(5'd10); rsv(5'd11); rsv(5'd12); rsv(5'd13);
    #2;
    expect_v("pre_rst_cnt", 64'd4); cmp(64'(cnt));
    rst = 1'b0; wr_en = 1'b1; ptr_wr = 5'd15; data_wr = 64'h15;
    rsv_en = 1'b1; ptr_rsv = 5'd14;
    #2;
    expect_v("mid_rst_rsv_ok", 64'd0); cmp(64'(ok));
    tick();
    rst = 1'b1; ptr_rd_1 = 5'd2; ptr_rd_2 = 5'd10;
    #2;
    expect_v("post_rst_cnt", 64'd0);   cmp(64'(cnt));
    expect_v("post_rst_data2", 64'd0); cmp(d1);
    expect_v("post_rst_busy10", 64'd0); cmp(64'(b2));
    ptr_rd_2 = 5'd15;
    #2;
    expect_v("post_rst_data15", 64'd0); cmp(d2);

    if (sb.size() != 0) begin
      errors++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
